instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/utils.sv | 11 +
 rtl/ifq_fifo.sv | 74 +++++++
 rtl/instr_fetch_queue.sv | 85 ++++++++
 tb/tb_instr_fetch_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/utils.sv
// Shared fetch-queue types and constants.
package utils;

  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
  } fetch_entry;

endpackage

// File: rtl/ifq_fifo.sv
// Circular storage for fetched entries: pointers, occupancy count and flush.
module ifq_fifo
  import utils::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   flush,
  input  logic                   w_en,
  input  fetch_entry             w_data,
  input  logic                   rd_en,
  output fetch_entry             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry    mem_q [DEPTH];
  logic          pop, push;

  // A pop on an empty queue is dropped; a write into a full queue only lands
  // when the same edge frees a slot.
  assign pop  = rd_en && (count_q != '0);
  assign push = w_en && ((count_q != CW'(DEPTH)) || pop);

  // Next-state for pointers and count; flush wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= w_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: PC sequencing, credit-based request issue and
// tracking of the single outstanding memory read feeding ifq_fifo.
module instr_fetch_queue
  import utils::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_rd_en,
  input  logic [31:0] i_imem_data,
  input  logic        i_dispatch_rd_en,
  input  logic        i_dispatch_jmp_valid,
  input  logic [31:0] i_dispatch_jmp_br_addr,
  output logic [31:0] o_fetch_instruction,
  output logic [31:0] o_fetch_pc_plus_4,
  output logic        o_fetch_empty_flag
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   issued_q, issued_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          empty;
  fetch_entry    head, wr_entry;

  // Entries held plus the read still on its way must leave a free slot.
  // Gating with the reset pin keeps the request low while reset is held.
  assign credit_used  = {1'b0, count} + (CW+1)'(inflight_q);
  assign o_imem_rd_en = i_rst_n && !i_dispatch_jmp_valid &&
                        (credit_used < (CW+1)'(DEPTH));

  // PC advances with every request; a redirect reloads it and drops the
  // outstanding read by clearing inflight.
  always_comb begin
    pc_d       = pc_q;
    issued_d   = issued_q;
    inflight_d = o_imem_rd_en;
    if (i_dispatch_jmp_valid) begin
      pc_d       = i_dispatch_jmp_br_addr;
      inflight_d = 1'b0;
    end else if (o_imem_rd_en) begin
      pc_d     = pc_q + 32'd4;
      issued_d = pc_q;
    end
  end

  // PC, issued-address and inflight registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q       <= RESET_PC;
      issued_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
    end
  end

  assign wr_entry = '{instr: i_imem_data, pc_plus_4: issued_q + 32'd4};

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .flush   (i_dispatch_jmp_valid),
    .w_en    (inflight_q),
    .w_data  (wr_entry),
    .rd_en   (i_dispatch_rd_en),
    .rd_data (head),
    .count   (count),
    .empty   (empty)
  );

  assign o_imem_addr         = pc_q;
  assign o_fetch_empty_flag  = empty;
  assign o_fetch_instruction = empty ? RISCV_NOP : head.instr;
  assign o_fetch_pc_plus_4   = empty ? 32'd0     : head.pc_plus_4;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] o_imem_addr;
  logic        o_imem_rd_en;
  logic [31:0] i_imem_data = '0;
  logic        i_dispatch_rd_en = 1'b0;
  logic        i_dispatch_jmp_valid = 1'b0;
  logic [31:0] i_dispatch_jmp_br_addr = '0;
  logic [31:0] o_fetch_instruction;
  logic [31:0] o_fetch_pc_plus_4;
  logic        o_fetch_empty_flag;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .o_imem_addr            (o_imem_addr),
    .o_imem_rd_en           (o_imem_rd_en),
    .i_imem_data            (i_imem_data),
    .i_dispatch_rd_en       (i_dispatch_rd_en),
    .i_dispatch_jmp_valid   (i_dispatch_jmp_valid),
    .i_dispatch_jmp_br_addr (i_dispatch_jmp_br_addr),
    .o_fetch_instruction    (o_fetch_instruction),
    .o_fetch_pc_plus_4      (o_fetch_pc_plus_4),
    .o_fetch_empty_flag     (o_fetch_empty_flag)
  );

  always #5 i_clk = ~i_clk;

  // Memory returns the requested address as the data word, one cycle later.
  always @(posedge i_clk) i_imem_data <= o_imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Head check: with data==address, a valid head holds instr = pc_plus_4 - 4.
  task automatic chk_head(input string name, input logic exp_empty, input logic [31:0] exp_pc4);
    chk({name, ".empty"}, 32'(o_fetch_empty_flag), 32'(exp_empty));
    chk({name, ".pc4"}, o_fetch_pc_plus_4, exp_empty ? 32'd0 : exp_pc4);
    chk({name, ".instr"}, o_fetch_instruction, exp_empty ? NOP : exp_pc4 - 32'd4);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_dispatch_rd_en = 1'b0;
    i_dispatch_jmp_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Drive at a negedge, let inputs settle, then cross one rising edge.
  task automatic drive(input logic rd, input logic jmp, input logic [31:0] tgt);
    i_dispatch_rd_en = rd;
    i_dispatch_jmp_valid = jmp;
    i_dispatch_jmp_br_addr = tgt;
    #1;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  logic [31:0] mpc;
  logic        mpend;
  logic [31:0] mpend_addr;

  task automatic model_reset();
    mq.delete();
    mpc = RESET_PC;
    mpend = 1'b0;
    mpend_addr = '0;
  endtask

  function automatic logic model_req(input logic jmp);
    return !jmp && ((mq.size() + int'(mpend)) < DEPTH);
  endfunction

  task automatic model_edge(input logic rd, input logic jmp, input logic [31:0] tgt);
    logic req;
    req = model_req(jmp);
    if (jmp) begin
      mq.delete();
      mpc = tgt;
      mpend = 1'b0;
    end else begin
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (mpend) mq.push_back(mpend_addr);
      if (req) begin
        mpend_addr = mpc;
        mpc = mpc + 32'd4;
      end
      mpend = req;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rd;
    logic        jmp;
    logic [31:0] tgt;
    logic        exp_rden;
    logic        exp_empty;
    logic [31:0] exp_pc4;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic rst_pulse;
    logic rd, jmp;
    logic [31:0] tgt;

    // Fill from reset with no pops, then a redirect from a full queue, then pops.
    tbl[0] = '{0, 0, 32'h0,        1, 1, 32'h0,        32'h0040_0004};
    tbl[1] = '{0, 0, 32'h0,        1, 0, 32'h0040_0004, 32'h0040_0008};
    tbl[2] = '{0, 0, 32'h0,        1, 0, 32'h0040_0004, 32'h0040_000C};
    tbl[3] = '{0, 0, 32'h0,        1, 0, 32'h0040_0004, 32'h0040_0010};
    tbl[4] = '{0, 0, 32'h0,        0, 0, 32'h0040_0004, 32'h0040_0010};
    tbl[5] = '{0, 0, 32'h0,        0, 0, 32'h0040_0004, 32'h0040_0010};
    tbl[6] = '{0, 1, 32'h0040_0100, 0, 1, 32'h0,        32'h0040_0100};
    tbl[7] = '{0, 0, 32'h0,        1, 1, 32'h0,        32'h0040_0104};
    tbl[8] = '{0, 0, 32'h0,        1, 0, 32'h0040_0104, 32'h0040_0108};
    tbl[9] = '{1, 0, 32'h0,        1, 0, 32'h0040_0108, 32'h0040_010C};

    do_reset();
    #1;
    chk("reset.addr", o_imem_addr, RESET_PC);
    chk_head("reset", 1'b1, 32'h0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rd, tbl[i].jmp, tbl[i].tgt);
      chk($sformatf("vec%0d.rden", i), 32'(o_imem_rd_en), 32'(tbl[i].exp_rden));
      cycle();
      chk($sformatf("vec%0d.addr", i), o_imem_addr, tbl[i].exp_addr);
      chk_head($sformatf("vec%0d", i), tbl[i].exp_empty, tbl[i].exp_pc4);
    end

    // Pop while empty is ignored; the first write still lands at the head.
    do_reset();
    drive(1, 0, 0); cycle();
    chk_head("pop_empty.e1", 1'b1, 32'h0);
    drive(1, 0, 0); cycle();
    chk_head("pop_empty.e2", 1'b0, 32'h0040_0004);

    // Redirect with a pop, three entries held and one read in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0); cycle(); end
    chk_head("flush3.pre", 1'b0, 32'h0040_0004);
    drive(1, 1, 32'h0040_0200);
    chk("flush3.rden", 32'(o_imem_rd_en), 32'd0);
    cycle();
    chk("flush3.addr", o_imem_addr, 32'h0040_0200);
    chk_head("flush3.e0", 1'b1, 32'h0);
    drive(0, 0, 0); cycle();
    chk_head("flush3.e1", 1'b1, 32'h0);
    drive(0, 0, 0); cycle();
    chk_head("flush3.e2", 1'b0, 32'h0040_0204);
    drive(0, 0, 0); cycle();
    chk_head("flush3.e3", 1'b0, 32'h0040_0204);
    drive(1, 0, 0); cycle();
    chk_head("flush3.e4", 1'b0, 32'h0040_0208);

    // Asynchronous reset between edges: two entries plus one in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0); cycle(); end
    chk_head("arst.pre", 1'b0, 32'h0040_0004);
    i_rst_n = 1'b0;
    #1;
    chk_head("arst.now", 1'b1, 32'h0);
    chk("arst.addr", o_imem_addr, RESET_PC);
    chk("arst.rden", 32'(o_imem_rd_en), 32'd0);
    #1 i_rst_n = 1'b1;
    drive(0, 0, 0); cycle();
    chk_head("arst.e1", 1'b1, 32'h0);
    drive(0, 0, 0); cycle();
    chk_head("arst.e2", 1'b0, 32'h0040_0004);

    // ---------------- random traffic vs model ----------------
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rd  = ($urandom % 4) != 0;
      jmp = ($urandom % 16) == 0;
      tgt = $urandom & 32'hFFFF_FFFC;
      rst_pulse = ($urandom % 250) == 0;
      if (rst_pulse) begin
        #1 i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("rnd.rst.empty", 32'(o_fetch_empty_flag), 32'd1);
        chk("rnd.rst.addr", o_imem_addr, RESET_PC);
        i_rst_n = 1'b1;
      end
      drive(rd, jmp, tgt);
      chk("rnd.rden", 32'(o_imem_rd_en), 32'(model_req(jmp)));
      @(posedge i_clk);
      model_edge(rd, jmp, tgt);
      @(negedge i_clk);
      chk("rnd.addr", o_imem_addr, mpc);
      if (mq.size() == 0) chk_head("rnd", 1'b1, 32'h0);
      else                chk_head("rnd", 1'b0, mq[0] + 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
